// File: rtl/mem_responder_pkg.sv
// Shared FSM state encodings, port selects and latched-request layout for the
// memory responder.
package mem_responder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM; the read port is registered and holds its
// value between read enables.
module mem_array #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Two-port (fetch/data) memory responder: data has priority, optional wait
// states, one RAM access per transaction.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ifAddr,
    output logic [31:0] instr,
    output logic        ifValid,
    input  logic        dataReq,
    input  logic [31:0] dataAddr,
    input  logic        dataWe,
    input  logic [31:0] dataWdata,
    output logic [31:0] dataRdata,
    output logic        memValid
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]            state_reg, state_next;
    logic [3:0]            count_reg, count_next;
    req_t                  req_reg, req_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
    logic                  if_valid_reg;
    logic                  mem_rd_valid_reg;
    logic [31:0]           instr_reg;
    logic [31:0]           rdata_reg;
    logic                  in_access;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_q;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{ifAddr[31:ADDR_WIDTH+2], ifAddr[1:0],
                                dataAddr[31:ADDR_WIDTH+2], dataAddr[1:0]};

    // Gating with rst_n keeps a reset asserted in ACCESS from committing a store.
    assign in_access = rst_n && (state_reg == ST_ACCESS);
    assign ram_we    = in_access && (req_reg.port == PORT_DATA) && req_reg.we;
    assign ram_re    = in_access && !((req_reg.port == PORT_DATA) && req_reg.we);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        req_next   = req_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (dataReq) begin
                    req_next = '{port: PORT_DATA, we: dataWe, wdata: dataWdata};
                    idx_next = dataAddr[ADDR_WIDTH+1:2];
                end else begin
                    req_next = '{port: PORT_FETCH, we: 1'b0, wdata: 32'd0};
                    idx_next = ifAddr[ADDR_WIDTH+1:2];
                end
                if (WAIT_STATES > 0) begin
                    state_next = ST_WAIT;
                    count_next = WAIT_LOAD;
                end else begin
                    state_next = ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = ST_ACCESS;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            ST_ACCESS: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            count_reg        <= 4'd0;
            req_reg          <= '0;
            idx_reg          <= '0;
            if_valid_reg     <= 1'b0;
            mem_rd_valid_reg <= 1'b0;
            instr_reg        <= 32'd0;
            rdata_reg        <= 32'd0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            req_reg          <= req_next;
            idx_reg          <= idx_next;
            if_valid_reg     <= ram_re && (req_reg.port == PORT_FETCH);
            mem_rd_valid_reg <= ram_re && (req_reg.port == PORT_DATA);
            if (if_valid_reg) begin
                instr_reg <= ram_q;
            end
            if (mem_rd_valid_reg) begin
                rdata_reg <= ram_q;
            end
        end
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_array (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (idx_reg),
        .wdata(req_reg.wdata),
        .rdata(ram_q)
    );

    // The RAM output is shown directly in the valid cycle and captured for holding.
    assign instr     = if_valid_reg ? ram_q : instr_reg;
    assign dataRdata = mem_rd_valid_reg ? ram_q : rdata_reg;
    assign ifValid   = if_valid_reg;
    assign memValid  = mem_rd_valid_reg | ram_we;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 runs with no wait states, instance 1 with three.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic [31:0] if_addr    [2];
    logic [31:0] instr      [2];
    logic        if_valid   [2];
    logic        data_req   [2];
    logic [31:0] data_addr  [2];
    logic        data_we    [2];
    logic [31:0] data_wdata [2];
    logic [31:0] data_rdata [2];
    logic        mem_valid  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .ifAddr(if_addr[0]), .instr(instr[0]),
        .ifValid(if_valid[0]), .dataReq(data_req[0]), .dataAddr(data_addr[0]),
        .dataWe(data_we[0]), .dataWdata(data_wdata[0]), .dataRdata(data_rdata[0]),
        .memValid(mem_valid[0])
    );

    mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n[1]), .ifAddr(if_addr[1]), .instr(instr[1]),
        .ifValid(if_valid[1]), .dataReq(data_req[1]), .dataAddr(data_addr[1]),
        .dataWe(data_we[1]), .dataWdata(data_wdata[1]), .dataRdata(data_rdata[1]),
        .memValid(mem_valid[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Returns at a falling edge where the FSM is in IDLE (fetch just completed).
    task automatic wait_idle(input int w);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_valid[w] && n < 200);
        if (!if_valid[w]) check("idle_timeout", {31'd0, if_valid[w]}, 32'd1);
    endtask

    task automatic data_op(input int w, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat,
                           input string tag, output logic [31:0] rd);
        int  lat = 0;
        int  if_seen = 0;
        bit  got = 0;
        wait_idle(w);
        data_req[w]   = 1'b1;
        data_we[w]    = we;
        data_addr[w]  = addr;
        data_wdata[w] = wdata;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            data_req[w] = 1'b0;
            data_we[w]  = 1'b0;
            @(negedge clk);
            if (if_valid[w]) if_seen++;
            if (mem_valid[w]) got = 1;
        end
        rd = data_rdata[w];
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prio"}, if_seen, 0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, mem_valid[w]}, 32'd0);
    endtask

    task automatic fetch(input int w, input logic [31:0] addr, input logic [31:0] exp,
                         input int exp_lat, input string tag);
        int lat = 0;
        bit got = 0;
        wait_idle(w);
        if_addr[w] = addr;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if_valid[w]) got = 1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_instr"}, instr[w], exp);
    endtask

    initial begin
        logic [31:0] rd;
        int          mv_seen;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; if_addr[i] = 32'd0; data_req[i] = 1'b0;
            data_addr[i] = 32'd0; data_we[i] = 1'b0; data_wdata[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_instr", instr[i], 32'd0);
            check("rst_rdata", data_rdata[i], 32'd0);
            check("rst_ifvalid", {31'd0, if_valid[i]}, 32'd0);
            check("rst_memvalid", {31'd0, mem_valid[i]}, 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // No wait states
        data_op(0, 1'b1, 32'h0000_0000, 32'h0000_0013, 1, "w0_st_word0", rd);
        fetch(0, 32'h0000_0000, 32'h0000_0013, 2, "w0_fetch0");
        data_op(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, "w0_st_10", rd);
        data_op(0, 1'b0, 32'h0000_0010, 32'h0, 2, "w0_ld_10", rd);
        check("w0_ld_10_data", rd, 32'hDEAD_BEEF);
        data_op(0, 1'b1, 32'h0000_0008, 32'hA5A5_5A5A, 1, "w0_st_08", rd);
        check("w0_rdata_hold", data_rdata[0], 32'hDEAD_BEEF);
        fetch(0, 32'h0000_000A, 32'hA5A5_5A5A, 2, "w0_fetch_0a");
        data_op(0, 1'b1, 32'h0000_4000, 32'h0000_0001, 1, "w0_st_wrap", rd);
        data_op(0, 1'b0, 32'h0000_0000, 32'h0, 2, "w0_ld_wrap", rd);
        check("w0_ld_wrap_data", rd, 32'h0000_0001);

        // Three wait states
        data_op(1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4, "w3_st_04", rd);
        data_op(1, 1'b0, 32'h0000_0004, 32'h0, 5, "w3_ld_04", rd);
        check("w3_ld_04_data", rd, 32'hCAFE_F00D);
        fetch(1, 32'h0000_0004, 32'hCAFE_F00D, 5, "w3_fetch_04");
        data_op(1, 1'b1, 32'h0000_0020, 32'h1111_1111, 4, "w3_st_20", rd);

        // Store to 0x20 aborted by reset while in WAIT
        wait_idle(1);
        data_req[1] = 1'b1; data_we[1] = 1'b1;
        data_addr[1] = 32'h0000_0020; data_wdata[1] = 32'h2222_2222;
        @(posedge clk);
        #1;
        data_req[1] = 1'b0; data_we[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("abort_instr", instr[1], 32'd0);
        check("abort_rdata", data_rdata[1], 32'd0);
        check("abort_ifvalid", {31'd0, if_valid[1]}, 32'd0);
        mv_seen = mem_valid[1] ? 1 : 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_valid[1]) mv_seen++;
        end
        check("abort_no_memvalid", mv_seen, 0);
        data_op(1, 1'b0, 32'h0000_0020, 32'h0, 5, "w3_ld_20", rd);
        check("w3_ld_20_data", rd, 32'h1111_1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
